// File: rtl/uart_rdata_sender.sv
// ---------------------------------------------------------------------------
// uart_rdata_sender
//
// Purpose:
//   Takes a 64-bit read-data snapshot when a start pulse arrives and sends it
//   to the UART transmitter as ASCII hex text, one byte per valid/ready
//   handshake.
//     dump mode : 8 hex digits of [31:0], SEP_CHAR, 8 hex digits of [63:32],
//                 then CR LF (19 bytes)
//     PC mode   : 8 hex digits of [31:0], then CR LF (10 bytes)
//   When TX accepts the last byte, flushing_wq pulses for one cycle. The dump
//   sequencer uses this pulse to fetch the next pair of words or to return to
//   idle.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   rdata_snd_start one-cycle request to send the current snapshot
//   rdata_snd       snapshot; [31:0] lower-address word, [63:32] next word
//   pc_print_sel    1 = PC mode (send [31:0] only); sampled with the start
//   abort           stop the line at once; no flushing_wq is produced
//   tx_data         ASCII byte to the UART TX
//   tx_valid        tx_data is valid
//   tx_ready        UART TX accepts a byte this cycle
//   flushing_wq     one-cycle pulse after the whole line has been accepted
//   sender_busy     a line is in progress (SEND or DONE)
// ---------------------------------------------------------------------------
module uart_rdata_sender #(
    parameter bit         HEX_LOWER = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    input  logic        abort,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        flushing_wq,
    output logic        sender_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] IDX_LAST_LO = 5'd7;
    localparam logic [4:0] IDX_CR      = 5'd17;
    localparam logic [4:0] IDX_LF      = 5'd18;

    state_t      state_reg,    state_next;
    logic [4:0]  char_idx_reg, char_idx_next;
    logic [63:0] data_reg,     data_next;
    logic        pc_mode_reg,  pc_mode_next;
    logic [7:0]  tx_data_reg,  tx_data_next;
    logic [4:0]  idx_adv;

    // One nibble converted to its ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] r;
        if (nib < 4'd10)
            r = 8'h30 + {4'h0, nib};
        else if (HEX_LOWER)
            r = 8'h61 + {4'h0, nib} - 8'd10;
        else
            r = 8'h41 + {4'h0, nib} - 8'd10;
        return r;
    endfunction

    // Character at position idx of a line built from snapshot d.
    function automatic logic [7:0] char_at(input logic [63:0] d,
                                           input logic [4:0]  idx);
        logic [7:0] r;
        logic [2:0] k;
        // Digit position inside the word. For idx 9..16 the low three bits
        // minus one give 0..7, so both words use the same nibble select.
        k = (idx < 5'd8) ? idx[2:0] : (idx[2:0] - 3'd1);
        r = 8'h00;
        if (idx < 5'd8)
            r = hex_ascii(d[{~k, 2'b00} +: 4]);
        else if (idx == 5'd8)
            r = SEP_CHAR;
        else if (idx <= 5'd16)
            r = hex_ascii(d[6'd32 + {1'b0, ~k, 2'b00} +: 4]);
        else if (idx == IDX_CR)
            r = 8'h0d;
        else if (idx == IDX_LF)
            r = 8'h0a;
        return r;
    endfunction

    // Index that follows the current one. PC mode skips the separator and
    // the high word and goes straight to CR.
    always_comb begin
        idx_adv = char_idx_reg + 5'd1;
        if (pc_mode_reg && (char_idx_reg == IDX_LAST_LO))
            idx_adv = IDX_CR;
    end

    always_comb begin
        state_next    = state_reg;
        char_idx_next = char_idx_reg;
        data_next     = data_reg;
        pc_mode_next  = pc_mode_reg;
        tx_data_next  = tx_data_reg;

        if (abort) begin
            // abort takes priority over any transfer or start in this cycle.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rdata_snd_start) begin
                        data_next     = rdata_snd;
                        pc_mode_next  = pc_print_sel;
                        char_idx_next = 5'd0;
                        // Preload the first character so that it appears
                        // together with tx_valid in the next cycle.
                        tx_data_next  = char_at(rdata_snd, 5'd0);
                        state_next    = SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (char_idx_reg == IDX_LF) begin
                            state_next = DONE;
                        end else begin
                            char_idx_next = idx_adv;
                            tx_data_next  = char_at(data_reg, idx_adv);
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            char_idx_reg <= 5'd0;
            data_reg     <= 64'd0;
            pc_mode_reg  <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            char_idx_reg <= char_idx_next;
            data_reg     <= data_next;
            pc_mode_reg  <= pc_mode_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    // All handshake outputs are decoded from the state register. An
    // asynchronous reset therefore clears them at once.
    assign tx_data     = tx_data_reg;
    assign tx_valid    = (state_reg == SEND);
    assign flushing_wq = (state_reg == DONE);
    assign sender_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rdata_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_rdata_sender
//
// Purpose:
//   Self-checking bench for uart_rdata_sender. Two instances share every
//   input: one uses lower-case hex digits and the other upper-case. A table
//   of line vectors is applied in a loop. Hand-written sequences cover reset,
//   abort and asynchronous reset in the middle of a line.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_uart_rdata_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdata_snd_start;
    logic [63:0] rdata_snd;
    logic        pc_print_sel;
    logic        abort;
    logic        tx_ready;

    logic [7:0]  tx_data_l,  tx_data_u;
    logic        tx_valid_l, tx_valid_u;
    logic        flush_l,    flush_u;
    logic        busy_l,     busy_u;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_rdata_sender dut_l (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdata_snd_start (rdata_snd_start),
        .rdata_snd       (rdata_snd),
        .pc_print_sel    (pc_print_sel),
        .abort           (abort),
        .tx_data         (tx_data_l),
        .tx_valid        (tx_valid_l),
        .tx_ready        (tx_ready),
        .flushing_wq     (flush_l),
        .sender_busy     (busy_l)
    );

    uart_rdata_sender #(.HEX_LOWER(1'b0)) dut_u (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdata_snd_start (rdata_snd_start),
        .rdata_snd       (rdata_snd),
        .pc_print_sel    (pc_print_sel),
        .abort           (abort),
        .tx_data         (tx_data_u),
        .tx_valid        (tx_valid_u),
        .tx_ready        (tx_ready),
        .flushing_wq     (flush_u),
        .sender_busy     (busy_u)
    );

    typedef logic [18:0][7:0] line_t;

    typedef struct packed {
        logic [63:0] data;
        logic        pc;
        logic        upper;      // observe the upper-case instance
        logic        bp;         // random backpressure on tx_ready
        logic        timing;     // check exact cycle positions
        logic [4:0]  inject_at;  // extra start pulse at this byte, 31 = none
        logic [4:0]  len;
        line_t       exp;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    function automatic line_t mk(input string s);
        line_t r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[i] = s[i];
        r[s.len()]     = 8'h0d;
        r[s.len() + 1] = 8'h0a;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run one line from the table and check every byte, hold stability,
    // flush count and optional exact timing.
    task automatic run_vec(input int vi);
        vec_t cur;
        int c, pos, flush_cnt, flush_cycle, first_cycle, tail;
        logic stall_prev, injected, v, f, b, busy_after;
        logic [7:0] d, held;
        cur = vecs[vi];
        pos = 0; flush_cnt = 0; flush_cycle = -1; first_cycle = -1; tail = 0;
        stall_prev = 1'b0; injected = 1'b0; busy_after = 1'b1; held = 8'h00;

        rdata_snd       = cur.data;
        pc_print_sel    = cur.pc;
        rdata_snd_start = 1'b1;
        tx_ready        = 1'b1;
        cyc();
        rdata_snd_start = 1'b0;
        // Altering the inputs after the start cycle must have no effect on the line.
        rdata_snd       = ~cur.data;
        pc_print_sel    = ~cur.pc;
        c = 1;

        while (c < 600 && tail < 25) begin
            if (pos == int'(cur.len)) tail++;
            tx_ready = cur.bp ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (!injected && cur.inject_at != 5'd31 && pos == int'(cur.inject_at)) begin
                rdata_snd_start = 1'b1;
                rdata_snd       = 64'h1111_2222_3333_4444;
                injected        = 1'b1;
            end else begin
                rdata_snd_start = 1'b0;
            end
            v = cur.upper ? tx_valid_u : tx_valid_l;
            d = cur.upper ? tx_data_u  : tx_data_l;
            f = cur.upper ? flush_u    : flush_l;
            b = cur.upper ? busy_u     : busy_l;

            if (c == flush_cycle + 1) busy_after = b;
            if (stall_prev) begin
                chk($sformatf("v%0d_hold_valid", vi), 64'(v), 64'd1);
                chk($sformatf("v%0d_hold_data", vi), 64'(d), 64'(held));
            end
            stall_prev = 1'b0;
            if (v) begin
                if (pos >= int'(cur.len)) begin
                    chk($sformatf("v%0d_stray_valid", vi), 64'(v), 64'd0);
                end else if (tx_ready) begin
                    chk($sformatf("v%0d_byte%0d", vi, pos), 64'(d), 64'(cur.exp[pos]));
                    if (first_cycle < 0) first_cycle = c;
                    pos++;
                end else begin
                    stall_prev = 1'b1;
                    held       = d;
                end
            end
            if (f) begin
                flush_cnt++;
                flush_cycle = c;
            end
            cyc();
            c++;
        end
        rdata_snd_start = 1'b0;
        tx_ready        = 1'b1;

        chk($sformatf("v%0d_len", vi), 64'(pos), 64'(cur.len));
        chk($sformatf("v%0d_flush_cnt", vi), 64'(flush_cnt), 64'd1);
        chk($sformatf("v%0d_busy_end", vi), 64'(cur.upper ? busy_u : busy_l), 64'd0);
        if (cur.timing) begin
            chk($sformatf("v%0d_first_cycle", vi), 64'(first_cycle), 64'd1);
            chk($sformatf("v%0d_flush_cycle", vi), 64'(flush_cycle), 64'(int'(cur.len) + 1));
            chk($sformatf("v%0d_busy_after", vi), 64'(busy_after), 64'd0);
        end
        $display("line %0d: %0d bytes, %0d flush pulse(s), flush at cycle %0d",
                 vi, pos, flush_cnt, flush_cycle);
    endtask

    // Start a dump line with tx_ready=1 and stop when char_idx 10 is on the bus.
    task automatic go_to_idx10();
        rdata_snd       = 64'h89abcdef_01234567;
        pc_print_sel    = 1'b0;
        tx_ready        = 1'b1;
        rdata_snd_start = 1'b1;
        cyc();
        rdata_snd_start = 1'b0;
        repeat (10) cyc();
        chk("idx10_valid", 64'(tx_valid_l), 64'd1);
        chk("idx10_data", 64'(tx_data_l), 64'h39);
    endtask

    task automatic quiet_window(input string name);
        int nv, nf;
        nv = 0; nf = 0;
        repeat (25) begin
            if (tx_valid_l) nv++;
            if (flush_l) nf++;
            cyc();
        end
        chk({name, "_no_valid"}, 64'(nv), 64'd0);
        chk({name, "_no_flush"}, 64'(nf), 64'd0);
    endtask

    initial begin
        vecs[0] = '{data: 64'h89abcdef_01234567, pc: 1'b0, upper: 1'b0, bp: 1'b0, timing: 1'b1,
                    inject_at: 5'd31, len: 5'd19, exp: mk("01234567 89abcdef")};
        vecs[1] = '{data: 64'hffffffff_00000080, pc: 1'b1, upper: 1'b0, bp: 1'b0, timing: 1'b1,
                    inject_at: 5'd31, len: 5'd10, exp: mk("00000080")};
        vecs[2] = '{data: 64'h89abcdef_01234567, pc: 1'b0, upper: 1'b0, bp: 1'b1, timing: 1'b0,
                    inject_at: 5'd31, len: 5'd19, exp: mk("01234567 89abcdef")};
        vecs[3] = '{data: 64'h0000000a_fedcba98, pc: 1'b0, upper: 1'b1, bp: 1'b0, timing: 1'b1,
                    inject_at: 5'd31, len: 5'd19, exp: mk("FEDCBA98 0000000A")};
        vecs[4] = '{data: 64'h0000000a_fedcba98, pc: 1'b1, upper: 1'b0, bp: 1'b1, timing: 1'b0,
                    inject_at: 5'd31, len: 5'd10, exp: mk("fedcba98")};
        vecs[5] = '{data: 64'h89abcdef_01234567, pc: 1'b0, upper: 1'b0, bp: 1'b0, timing: 1'b1,
                    inject_at: 5'd5, len: 5'd19, exp: mk("01234567 89abcdef")};

        rst_n = 1'b0; rdata_snd_start = 1'b0; rdata_snd = 64'd0;
        pc_print_sel = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_tx_data", 64'(tx_data_l), 64'h00);
        chk("rst_tx_valid", 64'(tx_valid_l), 64'd0);
        chk("rst_flush", 64'(flush_l), 64'd0);
        chk("rst_busy", 64'(busy_l), 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", 64'(tx_valid_l), 64'd0);
        chk("post_rst_busy", 64'(busy_l), 64'd0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Abort with char_idx at 10: tx_valid drops the next cycle and no flush follows.
        go_to_idx10();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_valid", 64'(tx_valid_l), 64'd0);
        chk("abort_busy", 64'(busy_l), 64'd0);
        quiet_window("abort");
        run_vec(0);

        // Asynchronous reset with char_idx at 10: outputs return to reset values at once.
        go_to_idx10();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(tx_valid_l), 64'd0);
        chk("arst_data", 64'(tx_data_l), 64'h00);
        chk("arst_busy", 64'(busy_l), 64'd0);
        chk("arst_flush", 64'(flush_l), 64'd0);
        cyc();
        rst_n = 1'b1;
        quiet_window("arst");
        run_vec(1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
